// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings and types for the hazard/forwarding unit.
// The forwarding-select encoding here is what the EXE operand muxes decode.
package hazard_forward_unit_pkg;

  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic hit_exe;
    logic hit_mem;
    logic load_use;
  } src_hit_t;

  // The youngest producer wins: EXE-slot writer beats MEM-slot writer.
  function automatic fwd_sel_e fwd_select(input src_hit_t hit);
    fwd_sel_e sel;
    if (hit.hit_exe) begin
      sel = FWD_MEM;
    end else if (hit.hit_mem) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage request and hazard/forwarding response bundle.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_wb_en;
  logic                  id_mem_read;
  logic                  fwd_en;
  logic                  branch_taken;
  logic                  mem_ready;
  logic                  stall_id;
  logic                  freeze_all;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dst, id_wb_en, id_mem_read,
           fwd_en, branch_taken, mem_ready,
    input  stall_id, freeze_all, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dst, id_wb_en, id_mem_read,
           fwd_en, branch_taken, mem_ready,
    output stall_id, freeze_all, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit_src_match.sv
// Compares one ID source register against the in-flight EXE and MEM writers.
module hazard_src_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  src_en,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  exe_valid,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] exe_dst,
  input  logic                  mem_valid,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  output src_hit_t              hit
);

  always_comb begin
    hit          = '0;
    hit.hit_exe  = src_en & exe_valid & exe_wb_en & (exe_dst == src);
    hit.hit_mem  = src_en & mem_valid & mem_wb_en & (mem_dst == src);
    hit.load_use = hit.hit_exe & exe_mem_read;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// RAW hazard detection, load-use stall and registered operand-forwarding selects
// for a 5-stage pipeline, with branch squash, memory-wait freeze and stall counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The WB-stage writer is not tracked: the register file writes on the falling
  // edge, so a WB producer is already visible to the ID read.
  logic                  exe_valid_q, exe_valid_d;
  logic                  exe_wb_en_q, exe_wb_en_d;
  logic                  exe_mem_read_q, exe_mem_read_d;
  logic [REG_ADDR_W-1:0] exe_dst_q, exe_dst_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wb_en_q, mem_wb_en_d;
  logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
  fwd_sel_e              fwd_sel1_q, fwd_sel1_d;
  fwd_sel_e              fwd_sel2_q, fwd_sel2_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  src_hit_t hit1_s, hit2_s;
  logic     fwd_on_s, freeze_s, raw_s, stall_s, issue_s;

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_src1 (
    .src_en(1'b1), .src(bus.id_src1),
    .exe_valid(exe_valid_q), .exe_wb_en(exe_wb_en_q), .exe_mem_read(exe_mem_read_q),
    .exe_dst(exe_dst_q), .mem_valid(mem_valid_q), .mem_wb_en(mem_wb_en_q),
    .mem_dst(mem_dst_q), .hit(hit1_s)
  );

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_src2 (
    .src_en(bus.id_two_src), .src(bus.id_src2),
    .exe_valid(exe_valid_q), .exe_wb_en(exe_wb_en_q), .exe_mem_read(exe_mem_read_q),
    .exe_dst(exe_dst_q), .mem_valid(mem_valid_q), .mem_wb_en(mem_wb_en_q),
    .mem_dst(mem_dst_q), .hit(hit2_s)
  );

  // Hazard decision; a taken branch squashes ID, so it never stalls.
  always_comb begin
    fwd_on_s = bus.fwd_en & (FWD_EN != 0);
    freeze_s = ~bus.mem_ready;
    if (fwd_on_s) begin
      raw_s = hit1_s.load_use | hit2_s.load_use;
    end else begin
      raw_s = hit1_s.hit_exe | hit1_s.hit_mem | hit2_s.hit_exe | hit2_s.hit_mem;
    end
    stall_s = bus.id_valid & raw_s & ~bus.branch_taken;
    issue_s = bus.id_valid & ~stall_s & ~bus.branch_taken;
  end

  // Next-state: slot shift, forwarding selects and saturating stall counter.
  always_comb begin
    exe_valid_d    = exe_valid_q;
    exe_wb_en_d    = exe_wb_en_q;
    exe_mem_read_d = exe_mem_read_q;
    exe_dst_d      = exe_dst_q;
    mem_valid_d    = mem_valid_q;
    mem_wb_en_d    = mem_wb_en_q;
    mem_dst_d      = mem_dst_q;
    fwd_sel1_d     = fwd_sel1_q;
    fwd_sel2_d     = fwd_sel2_q;
    stall_count_d  = stall_count_q;
    if (freeze_s) begin
      stall_count_d = stall_count_q;
    end else begin
      mem_valid_d    = exe_valid_q;
      mem_wb_en_d    = exe_wb_en_q;
      mem_dst_d      = exe_dst_q;
      exe_valid_d    = issue_s;
      exe_wb_en_d    = issue_s & bus.id_wb_en;
      exe_mem_read_d = issue_s & bus.id_mem_read;
      exe_dst_d      = issue_s ? bus.id_dst : {REG_ADDR_W{1'b0}};
      if (issue_s && fwd_on_s) begin
        fwd_sel1_d = fwd_select(hit1_s);
        fwd_sel2_d = fwd_select(hit2_s);
      end else begin
        fwd_sel1_d = FWD_RF;
        fwd_sel2_d = FWD_RF;
      end
      if (stall_s && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + CNT_ONE;
      end else begin
        stall_count_d = stall_count_q;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_valid_q    <= 1'b0;
      exe_wb_en_q    <= 1'b0;
      exe_mem_read_q <= 1'b0;
      exe_dst_q      <= {REG_ADDR_W{1'b0}};
      mem_valid_q    <= 1'b0;
      mem_wb_en_q    <= 1'b0;
      mem_dst_q      <= {REG_ADDR_W{1'b0}};
      fwd_sel1_q     <= FWD_RF;
      fwd_sel2_q     <= FWD_RF;
      stall_count_q  <= {CNT_W{1'b0}};
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_wb_en_q    <= exe_wb_en_d;
      exe_mem_read_q <= exe_mem_read_d;
      exe_dst_q      <= exe_dst_d;
      mem_valid_q    <= mem_valid_d;
      mem_wb_en_q    <= mem_wb_en_d;
      mem_dst_q      <= mem_dst_d;
      fwd_sel1_q     <= fwd_sel1_d;
      fwd_sel2_q     <= fwd_sel2_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign bus.stall_id    = stall_s;
  assign bus.freeze_all  = freeze_s;
  assign bus.fwd_sel1    = fwd_sel1_q;
  assign bus.fwd_sel2    = fwd_sel2_q;
  assign bus.stall_count = stall_count_q;

endmodule
